// File: rtl/axi4_lite_reg_master.sv
// AXI4-Lite initiator: turns single register commands (index, read/write, data)
// into one AXI4-Lite transaction at a time and returns data/response on a valid/ready channel.
module axi4_lite_reg_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR = '0,
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_REGISTERS = 16,
  localparam int IDX_W = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_write,
  input  logic [IDX_W-1:0]            i_cmd_idx,
  input  logic [REGISTER_WIDTH-1:0]   i_cmd_data,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [REGISTER_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_busy,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]                  axi_awprot,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [2:0]                  axi_arprot,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rvalid,
  output logic                        axi_rready
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int ADDR_SHIFT = $clog2(STRB_W);
  localparam logic [IDX_W:0] REG_COUNT = NUM_REGISTERS[IDX_W:0];

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                      state, state_next;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                        aw_done, w_done;
  logic [REGISTER_WIDTH-1:0]   rsp_data_q;
  logic [1:0]                  rsp_resp_q;
  logic                        cmd_fire, idx_oor, aw_hs, w_hs;

  assign cmd_fire = i_cmd_valid && o_cmd_ready;
  assign idx_oor  = {1'b0, i_cmd_idx} >= REG_COUNT;
  assign aw_hs    = axi_awvalid && axi_awready;
  assign w_hs     = axi_wvalid && axi_wready;

  assign axi_awaddr = addr_q;
  assign axi_araddr = addr_q;
  assign axi_awprot = 3'b000;
  assign axi_arprot = 3'b000;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = '1;
  assign o_rsp_data = rsp_data_q;
  assign o_rsp_resp = rsp_resp_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // AW and W complete independently; leave WR only once both have handshaken
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = idx_oor ? RSP : (i_cmd_write ? WR : RD_ADDR);
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
      WR_RESP: if (axi_bvalid) state_next = RSP;
      RD_ADDR: if (axi_arready) state_next = RD_DATA;
      RD_DATA: if (axi_rvalid) state_next = RSP;
      RSP:     if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = (state != IDLE);
    case (state)
      IDLE:    o_cmd_ready = !rst;
      WR: begin
        axi_awvalid = !aw_done;
        axi_wvalid  = !w_done;
      end
      WR_RESP: axi_bready  = 1'b1;
      RD_ADDR: axi_arvalid = 1'b1;
      RD_DATA: axi_rready  = 1'b1;
      RSP:     o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Out-of-range commands preload the local error code so RSP needs no extra path
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= 2'b00;
    end else begin
      if (cmd_fire) begin
        addr_q     <= AXI_BASE_ADDR + (AXI_ADDR_WIDTH'(i_cmd_idx) << ADDR_SHIFT);
        wdata_q    <= AXI_DATA_WIDTH'(i_cmd_data);
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        rsp_data_q <= '0;
        rsp_resp_q <= idx_oor ? 2'b10 : 2'b00;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (axi_bvalid && axi_bready) rsp_resp_q <= axi_bresp;
      if (axi_rvalid && axi_rready) begin
        rsp_data_q <= axi_rdata[REGISTER_WIDTH-1:0];
        rsp_resp_q <= axi_rresp;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_master.sv
// Bench for axi4_lite_reg_master: behavioural AXI4-Lite slave with programmable
// ready delays and response codes, plus a register-level reference model.
module tb_axi4_lite_reg_master;

  localparam int NREG = 12;
  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [3:0]  i_cmd_idx;
  logic [31:0] i_cmd_data;
  logic        o_rsp_valid, i_rsp_ready, o_busy;
  logic [31:0] o_rsp_data;
  logic [1:0]  o_rsp_resp;
  logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
  logic [2:0]  axi_awprot, axi_arprot;
  logic [3:0]  axi_wstrb;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0]  axi_bresp, axi_rresp;

  axi4_lite_reg_master #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_BASE_ADDR(BASE),
    .REGISTER_WIDTH(32), .NUM_REGISTERS(NREG)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_idx(i_cmd_idx), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_resp(o_rsp_resp), .o_busy(o_busy),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  // slave configuration and recorded activity
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  bit          stray = 1'b0;
  int          aw_wait, w_wait, ar_wait;
  bit          have_aw, have_w, b_pend, r_pend;
  logic [31:0] smem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] aw_addr_rec, ar_addr_rec, w_data_rec, r_data_next, off;
  logic [3:0]  w_strb_rec;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc;
  int          awv_cyc = 0, wv_cyc = 0, arv_cyc = 0, stab_viol = 0;
  logic        prev_awv = 0, prev_aw_hs = 0, prev_wv = 0, prev_w_hs = 0, prev_arv = 0, prev_ar_hs = 0;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr;

  // Slave decisions are made on the falling edge so every handshake is known
  // half a cycle before the rising edge that completes it.
  always @(negedge clk) begin
    awv_cyc += int'(axi_awvalid);
    wv_cyc  += int'(axi_wvalid);
    arv_cyc += int'(axi_arvalid);
    if (!rst) begin
      if (prev_awv && !prev_aw_hs && (!axi_awvalid || axi_awaddr !== prev_awaddr)) stab_viol++;
      if (prev_wv && !prev_w_hs && (!axi_wvalid || axi_wdata !== prev_wdata)) stab_viol++;
      if (prev_arv && !prev_ar_hs && (!axi_arvalid || axi_araddr !== prev_araddr)) stab_viol++;
    end
    if (rst) begin
      axi_awready = 0; axi_wready = 0; axi_arready = 0; axi_bvalid = 0; axi_rvalid = 0;
      axi_bresp = 0; axi_rresp = 0; axi_rdata = 0;
      have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
      aw_wait = aw_delay; w_wait = w_delay; ar_wait = ar_delay;
    end else begin
      if (b_pend) begin
        axi_bvalid = 1; axi_bresp = bresp_cfg;
        if (axi_bready) begin b_cnt++; b_cyc = cyc + 1; b_pend = 0; end
      end else if (stray) begin
        axi_bvalid = 1; axi_bresp = 2'b11;
      end else axi_bvalid = 0;
      if (r_pend) begin
        axi_rvalid = 1; axi_rresp = rresp_cfg; axi_rdata = r_data_next;
        if (axi_rready) begin r_cnt++; r_cyc = cyc + 1; r_pend = 0; end
      end else if (stray) begin
        axi_rvalid = 1; axi_rresp = 2'b11; axi_rdata = 32'hBAD0_BAD0;
      end else axi_rvalid = 0;
      if (axi_awvalid && !have_aw) begin
        if (aw_wait == 0) begin
          axi_awready = 1; have_aw = 1; aw_addr_rec = axi_awaddr; aw_cnt++; aw_cyc = cyc + 1;
        end else begin axi_awready = 0; aw_wait--; end
      end else begin axi_awready = 0; aw_wait = aw_delay; end
      if (axi_wvalid && !have_w) begin
        if (w_wait == 0) begin
          axi_wready = 1; have_w = 1; w_data_rec = axi_wdata; w_strb_rec = axi_wstrb; w_cnt++; w_cyc = cyc + 1;
        end else begin axi_wready = 0; w_wait--; end
      end else begin axi_wready = 0; w_wait = w_delay; end
      if (have_aw && have_w) begin
        off = (aw_addr_rec - BASE) >> 2;
        smem[off[3:0]] = w_data_rec;
        have_aw = 0; have_w = 0; b_pend = 1;
      end
      if (axi_arvalid && !r_pend) begin
        if (ar_wait == 0) begin
          axi_arready = 1; ar_addr_rec = axi_araddr; ar_cnt++; ar_cyc = cyc + 1;
          off = (axi_araddr - BASE) >> 2;
          r_data_next = smem[off[3:0]]; r_pend = 1;
        end else begin axi_arready = 0; ar_wait--; end
      end else begin axi_arready = 0; ar_wait = ar_delay; end
    end
    prev_awv = axi_awvalid; prev_aw_hs = axi_awvalid && axi_awready; prev_awaddr = axi_awaddr;
    prev_wv  = axi_wvalid;  prev_w_hs  = axi_wvalid && axi_wready;   prev_wdata  = axi_wdata;
    prev_arv = axi_arvalid; prev_ar_hs = axi_arvalid && axi_arready; prev_araddr = axi_araddr;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic applyStimulus(input logic wr, input logic [3:0] idx, input logic [31:0] data,
                               output int acc);
    int n = 0;
    i_cmd_valid = 1; i_cmd_write = wr; i_cmd_idx = idx; i_cmd_data = data;
    while (!o_cmd_ready && n < 100) begin @(negedge clk); n++; end
    checkOutput("cmd_accept_timeout", o_cmd_ready, 1);
    acc = cyc + 1;
    @(negedge clk);
    i_cmd_valid = 0; i_cmd_data = $urandom;
  endtask

  task automatic runTxn(input string tag, input logic wr, input logic [3:0] idx, input logic [31:0] data,
                        input int awd, input int wd, input int ard,
                        input logic [1:0] br, input logic [1:0] rr, input int hold);
    int acc, n, lat, exp_lat, slow_w;
    int aw0, w0, b0, ar0, r0, awv0, wv0, arv0;
    logic [31:0] exp_d, exp_addr;
    logic [1:0]  exp_r;
    bit in_range;
    aw_delay = awd; w_delay = wd; ar_delay = ard; bresp_cfg = br; rresp_cfg = rr;
    @(negedge clk);
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    awv0 = awv_cyc; wv0 = wv_cyc; arv0 = arv_cyc;
    in_range = (int'(idx) < NREG);
    exp_addr = BASE + 32'(idx) * 32'd4;
    slow_w = (awd > wd) ? awd : wd;
    if (!in_range) begin exp_d = 0; exp_r = 2'b10; exp_lat = 1; end
    else if (wr) begin exp_d = 0; exp_r = br; ref_mem[idx] = data; exp_lat = 3 + slow_w; end
    else begin exp_d = ref_mem[idx]; exp_r = rr; exp_lat = 3 + ard; end

    applyStimulus(wr, idx, data, acc);
    checkOutput({tag, "_busy"}, o_busy, 1);
    n = 0;
    while (!o_rsp_valid && n < 100) begin @(negedge clk); n++; end
    checkOutput({tag, "_rsp_timeout"}, o_rsp_valid, 1);
    lat = cyc + 1 - acc;
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_data"}, o_rsp_data, exp_d);
    checkOutput({tag, "_resp"}, o_rsp_resp, exp_r);
    checkOutput({tag, "_stability"}, stab_viol, 0);
    if (!in_range) begin
      checkOutput({tag, "_no_aw_w_ar"}, (aw_cnt - aw0) + (w_cnt - w0) + (ar_cnt - ar0), 0);
      checkOutput({tag, "_no_valids"}, (awv_cyc - awv0) + (wv_cyc - wv0) + (arv_cyc - arv0), 0);
    end else if (wr) begin
      checkOutput({tag, "_hs_counts"}, {8'(aw_cnt - aw0), 8'(w_cnt - w0), 8'(b_cnt - b0), 8'(ar_cnt - ar0)}, 32'h01010100);
      checkOutput({tag, "_awaddr"}, aw_addr_rec, exp_addr);
      checkOutput({tag, "_wdata"}, w_data_rec, data);
      checkOutput({tag, "_wstrb"}, w_strb_rec, 4'hF);
      checkOutput({tag, "_aw_cyc"}, aw_cyc, acc + 1 + awd);
      checkOutput({tag, "_w_cyc"}, w_cyc, acc + 1 + wd);
      checkOutput({tag, "_b_cyc"}, b_cyc, acc + 2 + slow_w);
      checkOutput({tag, "_awvalid_cycles"}, awv_cyc - awv0, awd + 1);
      checkOutput({tag, "_wvalid_cycles"}, wv_cyc - wv0, wd + 1);
    end else begin
      checkOutput({tag, "_hs_counts"}, {8'(aw_cnt - aw0), 8'(w_cnt - w0), 8'(ar_cnt - ar0), 8'(r_cnt - r0)}, 32'h00000101);
      checkOutput({tag, "_araddr"}, ar_addr_rec, exp_addr);
      checkOutput({tag, "_ar_cyc"}, ar_cyc, acc + 1 + ard);
      checkOutput({tag, "_r_cyc"}, r_cyc, acc + 2 + ard);
    end
    // while the response is held off, a competing command must not be taken
    for (int i = 0; i < hold; i++) begin
      i_cmd_valid = 1; i_cmd_write = 0; i_cmd_idx = 4'd1;
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, o_rsp_valid, 1);
      checkOutput({tag, "_hold_data"}, o_rsp_data, exp_d);
      checkOutput({tag, "_hold_resp"}, o_rsp_resp, exp_r);
      checkOutput({tag, "_hold_cmd_ready"}, o_cmd_ready, 0);
    end
    i_cmd_valid = 0;
    i_rsp_ready = 1;
    @(negedge clk);
    i_rsp_ready = 0;
    checkOutput({tag, "_rsp_done"}, o_rsp_valid, 0);
    checkOutput({tag, "_idle_ready"}, {o_cmd_ready, o_busy}, 2'b10);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_valids"}, {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 5'b0);
    checkOutput({tag, "_rsp"}, {o_rsp_valid, o_rsp_resp, o_rsp_data}, 35'b0);
  endtask

  initial begin
    int acc;
    logic wr;
    logic [3:0] idx;
    logic [1:0] codes [3];
    codes[0] = 2'b00; codes[1] = 2'b10; codes[2] = 2'b11;
    for (int i = 0; i < 16; i++) begin
      smem[i] = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end
    smem[5] = 32'h1234_5678;
    ref_mem[5] = 32'h1234_5678;
    rst = 1; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_idx = 0; i_cmd_data = 0; i_rsp_ready = 0;
    repeat (3) @(negedge clk);
    checkQuiet("reset");
    checkOutput("reset_cmd_ready", {o_cmd_ready, o_busy}, 2'b00);
    rst = 0;
    @(negedge clk);
    checkOutput("post_reset_cmd_ready", {o_cmd_ready, o_busy}, 2'b10);

    $display("[TB] directed transactions");
    runTxn("wr_idx3", 1, 4'd3, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 2'b00, 0);
    runTxn("rd_idx5_hold", 0, 4'd5, 32'h0, 0, 0, 0, 2'b00, 2'b00, 5);
    runTxn("wr_aw_slow", 1, 4'd7, 32'hCAFE_0001, 3, 0, 0, 2'b00, 2'b00, 0);
    runTxn("wr_w_slow", 1, 4'd8, 32'h0BAD_F00D, 0, 2, 0, 2'b00, 2'b00, 1);
    runTxn("rd_idx7", 0, 4'd7, 32'h0, 0, 0, 2, 2'b00, 2'b00, 0);
    runTxn("oor_wr_idx13", 1, 4'd13, 32'hFFFF_FFFF, 0, 0, 0, 2'b00, 2'b00, 0);
    runTxn("oor_rd_idx12", 0, 4'd12, 32'h0, 0, 0, 0, 2'b00, 2'b00, 2);
    runTxn("wr_idx11", 1, 4'd11, 32'h1111_2222, 0, 0, 0, 2'b00, 2'b00, 0);
    runTxn("rd_idx11_slverr", 0, 4'd11, 32'h0, 0, 0, 0, 2'b00, 2'b10, 0);
    runTxn("wr_idx0_decerr", 1, 4'd0, 32'h0000_0042, 1, 1, 0, 2'b11, 2'b00, 0);

    $display("[TB] stray B/R valids while idle");
    stray = 1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stray_readies", {axi_bready, axi_rready, o_rsp_valid, o_busy}, 4'b0);
    end
    stray = 0;

    $display("[TB] reset during write address phase");
    aw_delay = 20; w_delay = 0;
    @(negedge clk);
    applyStimulus(1, 4'd2, 32'h55AA_55AA, acc);
    checkOutput("rst_mid_awvalid", axi_awvalid, 1);
    rst = 1;
    @(negedge clk);
    checkQuiet("rst_mid");
    checkOutput("rst_mid_cmd_ready", o_cmd_ready, 0);
    @(negedge clk);
    rst = 0;
    aw_delay = 0;
    @(negedge clk);
    checkOutput("rst_release_ready", {o_cmd_ready, o_busy}, 2'b10);
    runTxn("rd_after_rst", 0, 4'd2, 32'h0, 0, 0, 0, 2'b00, 2'b00, 0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 13));
      runTxn($sformatf("rnd%0d", t), wr, idx, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             codes[$urandom_range(0, 2)], codes[$urandom_range(0, 2)], $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
